// File: rtl/module2_rr_fifo_if.sv
// module2_rr_fifo_if: producer operand/mode bundle and consumer drain port of the round-robin combiner FIFO.
interface module2_rr_fifo_if #(
   parameter int WIDTH = 2,
   parameter int NUM_CH = 2,
   parameter int DEPTH = 4
);
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int LVL_W = $clog2(DEPTH + 1);
   logic [1:0] mode;
   logic [NUM_CH-1:0] in_valid;
   logic [NUM_CH-1:0] in_ready;
   logic [NUM_CH*WIDTH-1:0] in0;
   logic [NUM_CH*WIDTH-1:0] in1;
   logic out_valid;
   logic out_ready;
   logic [WIDTH-1:0] out;
   logic [CH_W-1:0] out_ch;
   logic [LVL_W-1:0] level;
   modport master(
      output mode, in_valid, in0, in1, out_ready,
      input in_ready, out_valid, out, out_ch, level
   );
   modport slave(
      input mode, in_valid, in0, in1, out_ready,
      output in_ready, out_valid, out, out_ch, level
   );
endinterface

// File: rtl/module2_rr_fifo.sv
// module2_rr_fifo: round-robin arbitration of NUM_CH operand pairs, combined per mode into a FWFT FIFO.
module module2_rr_fifo #(
   parameter int WIDTH = 2,
   parameter int NUM_CH = 2,
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic reset,
   module2_rr_fifo_if.slave bus
);
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH+CH_W-1:0] mem [DEPTH];
   logic [PW-1:0] rd, wr;
   logic [LVL_W-1:0] count;
   logic [CH_W-1:0] rr, sel;
   logic found, pop, space, push;
   logic [WIDTH-1:0] a, b, res;
   assign bus.out_valid = count != '0;
   assign pop = bus.out_valid & bus.out_ready;
   assign space = (count != LVL_W'(DEPTH)) | pop;
   // Descending scan so the channel closest to rr is the last, winning, assignment.
   always_comb begin
      sel = '0;
      found = 1'b0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (bus.in_valid[CH_W'((int'(rr) + k) % NUM_CH)]) begin
            sel = CH_W'((int'(rr) + k) % NUM_CH);
            found = 1'b1;
         end
      end
   end
   assign push = found & space & ~reset;
   assign bus.in_ready = push ? NUM_CH'(1) << sel : '0;
   assign a = bus.in0[sel*WIDTH +: WIDTH];
   assign b = bus.in1[sel*WIDTH +: WIDTH];
   always_comb res = bus.mode == 2'b00 ? a : bus.mode == 2'b01 ? a ^ b : bus.mode == 2'b10 ? a & b : a + b;
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         rd <= '0;
         wr <= '0;
         rr <= '0;
      end else begin
         count <= count + LVL_W'(push) - LVL_W'(pop);
         if (pop) rd <= rd + 1'b1;
         if (push) begin
            wr <= wr + 1'b1;
            rr <= sel == CH_W'(NUM_CH - 1) ? '0 : sel + 1'b1;
         end
      end
   end
   always_ff @(posedge clk) if (push) mem[wr] <= {res, sel};
   assign bus.out = bus.out_valid ? mem[rd][WIDTH+CH_W-1:CH_W] : '0;
   assign bus.out_ch = bus.out_valid ? mem[rd][CH_W-1:0] : '0;
   assign bus.level = count;
endmodule
